// File: rtl/nes_joypad_events.sv
// Turns NES pad button edges into one-byte press/release events queued for the CPU.
// Define JOYEVT_IRQ_EN to add the irq output and the irq_en write port.
module nes_joypad_events #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned SETTLE_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pad_n_i,
  input  logic        rs_i,
  input  logic        rd_i,
`ifdef JOYEVT_IRQ_EN
  input  logic        wr_i,
  input  logic        wdata_i,
  output logic        irq_o,
`endif
  output logic [7:0]  to_cpu_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {StSettle, StIdle, StScan} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       settle_q, settle_d;
  logic [15:0]           ref_q, ref_d;
  logic [15:0]           snap_q, snap_d;
  logic [3:0]            idx_q, idx_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            to_cpu_q, to_cpu_d;
  logic [7:0]            mem [Depth];

  logic       push, pop, full, nonempty, advance, status5;
  logic [7:0] push_data;

  assign full     = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign nonempty = (count_q != '0);
  assign pop      = ~rs_i & rd_i & nonempty;

  // Scanner: one bit per clock; a full FIFO stalls on the current bit until a pop frees a slot.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    ref_d     = ref_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    push      = 1'b0;
    advance   = 1'b0;
    push_data = {~snap_q[idx_q], idx_q[3], 3'b000, idx_q[2:0]};
    unique case (state_q)
      StSettle: begin
        ref_d    = pad_n_i;
        settle_d = settle_q + 1'b1;
        if (settle_q == CntW'(SETTLE_CYCLES - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (pad_n_i != ref_q) begin
          snap_d  = pad_n_i;
          idx_d   = 4'd0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (snap_q[idx_q] == ref_q[idx_q]) begin
          advance = 1'b1;
        end else if (!full || pop) begin
          push          = 1'b1;
          ref_d[idx_q]  = snap_q[idx_q];
          advance       = 1'b1;
        end
        if (advance) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = StIdle;
        end
      end
      default: state_d = StSettle;
    endcase
  end

`ifdef JOYEVT_IRQ_EN
  logic irq_en_q, irq_q;
  assign status5 = irq_en_q;
  assign irq_o   = irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_i) irq_en_q <= wdata_i;
      irq_q <= irq_en_q & nonempty;
    end
  end
`else
  assign status5 = (state_q != StSettle);
`endif

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (rs_i) begin
      to_cpu_d = {nonempty, full, status5, 5'(count_q)};
    end else begin
      to_cpu_d = nonempty ? mem[rptr_q] : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StSettle;
      settle_q <= '0;
      ref_q    <= 16'hFFFF;
      snap_q   <= 16'hFFFF;
      idx_q    <= 4'd0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      to_cpu_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ref_q    <= ref_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      to_cpu_q <= to_cpu_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= push_data;
  end

  assign to_cpu_o = to_cpu_q;

endmodule

// File: tb/tb_nes_joypad_events.sv
// Directed bench: a 16-deep instance for the main flows and a 4-deep one for full/stall behaviour.
module tb_nes_joypad_events;

  localparam int unsigned Settle = 16;
`ifdef JOYEVT_IRQ_EN
  localparam logic Stb = 1'b0;
`else
  localparam logic Stb = 1'b1;
`endif

  typedef struct {
    logic        rs;
    logic        rd;
    int unsigned pre;
    logic [7:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pad_n;
  logic        rs, rd, sel;
  logic [7:0]  to_cpu_a, to_cpu_b, got;
  int          n_vec, n_fail;
  vec_t        t1[18];
  vec_t        t3[9];
`ifdef JOYEVT_IRQ_EN
  logic wr, wdata, irq_a, irq_b;
`endif

  always #5 clk = ~clk;

  nes_joypad_events #(.DEPTH_LOG2(4), .SETTLE_CYCLES(Settle)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .pad_n_i (pad_n),
    .rs_i    (rs),
    .rd_i    (rd),
`ifdef JOYEVT_IRQ_EN
    .wr_i    (wr),
    .wdata_i (wdata),
    .irq_o   (irq_a),
`endif
    .to_cpu_o(to_cpu_a)
  );

  nes_joypad_events #(.DEPTH_LOG2(2), .SETTLE_CYCLES(Settle)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .pad_n_i (pad_n),
    .rs_i    (rs),
    .rd_i    (rd),
`ifdef JOYEVT_IRQ_EN
    .wr_i    (wr),
    .wdata_i (wdata),
    .irq_o   (irq_b),
`endif
    .to_cpu_o(to_cpu_b)
  );

  function automatic logic [7:0] cur();
    return sel ? to_cpu_b : to_cpu_a;
  endfunction

  function automatic logic [7:0] stat(input logic ne, input logic fu, input logic [4:0] cnt);
    return {ne, fu, Stb, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic access(input logic r_s, input logic r_d, output logic [7:0] v);
    rs = r_s;
    rd = r_d;
    tick();
    rd = 1'b0;
    v  = cur();
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [7:0] r;
    repeat (v.pre) tick();
    access(v.rs, v.rd, r);
    check(name, r, v.exp);
  endtask

  // Holds inputs through reset, then confirms no event and status bit5 clear for the whole window.
  task automatic reset_and_settle();
    logic [7:0] r;
    rst = 1'b1;
    tick();
    check("reset to_cpu", cur(), 8'h00);
    rst = 1'b0;
    for (int k = 0; k < int'(Settle); k++) begin
      access(1'b1, 1'b0, r);
      check("settle status", r, 8'h00);
    end
    access(1'b1, 1'b0, r);
    check("settled status", r, stat(1'b0, 1'b0, 5'd0));
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b1;
    pad_n  = 16'h0000;
    rs     = 1'b0;
    rd     = 1'b0;
    sel    = 1'b0;
`ifdef JOYEVT_IRQ_EN
    wr     = 1'b0;
    wdata  = 1'b0;
`endif

    t1[0] = '{rs: 1'b1, rd: 1'b0, pre: 0, exp: stat(1'b1, 1'b1, 5'd16)};
    for (int i = 0; i < 16; i++) begin
      t1[i+1] = '{rs: 1'b0, rd: 1'b1, pre: 0,
                  exp: (i < 8) ? 8'(i) : 8'(8'h40 + i - 8)};
    end
    t1[17] = '{rs: 1'b1, rd: 1'b0, pre: 0, exp: stat(1'b0, 1'b0, 5'd0)};

    t3[0] = '{rs: 1'b0, rd: 1'b1, pre: 0,  exp: 8'hC0};
    t3[1] = '{rs: 1'b1, rd: 1'b0, pre: 20, exp: stat(1'b1, 1'b1, 5'd4)};
    t3[2] = '{rs: 1'b0, rd: 1'b1, pre: 0,  exp: 8'h40};
    t3[3] = '{rs: 1'b0, rd: 1'b1, pre: 0,  exp: 8'hC0};
    t3[4] = '{rs: 1'b0, rd: 1'b1, pre: 0,  exp: 8'h40};
    t3[5] = '{rs: 1'b0, rd: 1'b1, pre: 0,  exp: 8'hC0};
    t3[6] = '{rs: 1'b0, rd: 1'b1, pre: 20, exp: 8'h40};
    t3[7] = '{rs: 1'b0, rd: 1'b1, pre: 0,  exp: 8'h00};
    t3[8] = '{rs: 1'b1, rd: 1'b0, pre: 0,  exp: stat(1'b0, 1'b0, 5'd0)};

    // All pressed during settle, then all released: sixteen release events in bit order.
    reset_and_settle();
    pad_n = 16'hFFFF;
    repeat (20) tick();
    foreach (t1[i]) run_vec("release sweep", t1[i]);

    // Single press of pad0 bit3, bounded latency.
    pad_n = 16'hFFF7;
    rs    = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (cur() == stat(1'b1, 1'b0, 5'd1)) break;
    end
    check("press latency status", cur(), stat(1'b1, 1'b0, 5'd1));
    access(1'b0, 1'b1, got);
    check("press event", got, 8'h83);
    access(1'b1, 1'b0, got);
    check("status after pop", got, stat(1'b0, 1'b0, 5'd0));

    // Pop on empty must not move the read pointer.
    access(1'b0, 1'b1, got);
    check("empty pop data", got, 8'h00);
    access(1'b1, 1'b0, got);
    check("empty pop status", got, stat(1'b0, 1'b0, 5'd0));
    pad_n = 16'hFFFF;
    repeat (20) tick();
    access(1'b0, 1'b0, got);
    check("peek after empty pop", got, 8'h03);
    access(1'b0, 1'b1, got);
    check("pop after empty pop", got, 8'h03);
    access(1'b1, 1'b0, got);
    check("drained status", got, stat(1'b0, 1'b0, 5'd0));

    // Reset mid-scan with three events queued and bit12 still unscanned.
    pad_n = 16'hEFF8;
    repeat (5) tick();
    access(1'b1, 1'b0, got);
    check("three queued", got, stat(1'b1, 1'b0, 5'd3));
    rst = 1'b1;
    #1;
    check("async rst to_cpu", cur(), 8'h00);
    reset_and_settle();
    repeat (20) tick();
    access(1'b1, 1'b0, got);
    check("no events after resettle", got, stat(1'b0, 1'b0, 5'd0));

`ifdef JOYEVT_IRQ_EN
    pad_n = 16'hEFF0;
    repeat (20) tick();
    check("irq gated off", {7'b0, irq_a}, 8'h00);
    access(1'b0, 1'b1, got);
    check("gated press event", got, 8'h83);
    wr    = 1'b1;
    wdata = 1'b1;
    tick();
    wr    = 1'b0;
    pad_n = 16'hEFF8;
    repeat (5) tick();
    check("irq at push edge", {7'b0, irq_a}, 8'h00);
    tick();
    check("irq after push", {7'b0, irq_a}, 8'h01);
    access(1'b0, 1'b1, got);
    check("irq release event", got, 8'h03);
    check("irq at pop edge", {7'b0, irq_a}, 8'h01);
    tick();
    check("irq after last pop", {7'b0, irq_a}, 8'h00);
`endif

    // 4-deep FIFO: fill with four edges, stall on the fifth with a sixth pending.
    pad_n = 16'hFFFF;
    reset_and_settle();
    sel = 1'b1;
    for (int e = 0; e < 5; e++) begin
      pad_n = (e % 2 == 0) ? 16'hFEFF : 16'hFFFF;
      repeat (20) tick();
    end
    access(1'b1, 1'b0, got);
    check("full stall status", got, stat(1'b1, 1'b1, 5'd4));
    pad_n = 16'hFFFF;
    repeat (5) tick();
    access(1'b1, 1'b0, got);
    check("still full", got, stat(1'b1, 1'b1, 5'd4));
    foreach (t3[i]) run_vec("stall drain", t3[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
